// File: rtl/l2_request_arbiter.sv
// Two-way arbiter for the shared L2 request port (icache vs dcache); grant held per transfer.
// Define L2_ARB_DCACHE_PRIORITY_EN for fixed dcache priority instead of round-robin tie-break.

package l2_arb_pkg;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;
endpackage

module l2_request_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              icache_l2_req_valid,
  input  memory_operation_e icache_l2_req_type,
  input  logic [XLEN-1:0]   icache_l2_req_address,
  output logic              icache_l2_req_fulfilled,
  input  logic              dcache_l2_req_valid,
  input  memory_operation_e dcache_l2_req_type,
  input  logic [XLEN-1:0]   dcache_l2_req_address,
  input  logic [XLEN-1:0]   dcache_l2_req_wdata,
  output logic              dcache_l2_req_fulfilled,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  output logic [XLEN-1:0]   l2_req_address,
  output logic [XLEN-1:0]   l2_req_wdata,
  input  logic              l2_req_fulfilled,
  output logic              icache_granted,
  output logic              dcache_granted
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StGrantI = 2'd1;
  localparam logic [1:0] StGrantD = 2'd2;

  logic [1:0] state_q, state_d;
  logic       tie_to_d;

`ifdef L2_ARB_DCACHE_PRIORITY_EN
  assign tie_to_d = 1'b1;
`else
  // last_grant: 1 = dcache owned most recently, 0 = icache.
  logic last_grant_q, last_grant_d;

  assign tie_to_d = ~last_grant_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_d == StGrantI) begin
      last_grant_d = 1'b0;
    end else if (state_d == StGrantD) begin
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (icache_l2_req_valid && dcache_l2_req_valid) begin
          state_d = tie_to_d ? StGrantD : StGrantI;
        end else if (icache_l2_req_valid) begin
          state_d = StGrantI;
        end else if (dcache_l2_req_valid) begin
          state_d = StGrantD;
        end
      end
      StGrantI: begin
        if (!icache_l2_req_valid) begin
          state_d = dcache_l2_req_valid ? StGrantD : StIdle;
        end
      end
      StGrantD: begin
        if (!dcache_l2_req_valid) begin
          state_d = icache_l2_req_valid ? StGrantI : StIdle;
        end
      end
      default: state_d = 'x;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner's valid gates everything, so a release or stray fulfilled pulse never leaks through.
  always_comb begin
    l2_req_valid            = 1'b0;
    l2_req_type             = LOAD;
    l2_req_address          = '0;
    l2_req_wdata            = '0;
    icache_l2_req_fulfilled = 1'b0;
    dcache_l2_req_fulfilled = 1'b0;
    icache_granted          = 1'b0;
    dcache_granted          = 1'b0;
    case (state_q)
      StIdle: ;
      StGrantI: begin
        icache_granted          = 1'b1;
        l2_req_valid            = icache_l2_req_valid;
        l2_req_type             = icache_l2_req_type;
        l2_req_address          = icache_l2_req_address;
        icache_l2_req_fulfilled = l2_req_fulfilled & icache_l2_req_valid;
      end
      StGrantD: begin
        dcache_granted          = 1'b1;
        l2_req_valid            = dcache_l2_req_valid;
        l2_req_type             = dcache_l2_req_type;
        l2_req_address          = dcache_l2_req_address;
        l2_req_wdata            = dcache_l2_req_wdata;
        dcache_l2_req_fulfilled = l2_req_fulfilled & dcache_l2_req_valid;
      end
      default: begin
        l2_req_valid            = 1'bx;
        l2_req_type             = memory_operation_e'(1'bx);
        l2_req_address          = 'x;
        l2_req_wdata            = 'x;
        icache_l2_req_fulfilled = 1'bx;
        dcache_l2_req_fulfilled = 1'bx;
        icache_granted          = 1'bx;
        dcache_granted          = 1'bx;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed self-checking bench for l2_request_arbiter.

module tb_l2_request_arbiter;
  import l2_arb_pkg::*;

  localparam int unsigned XLEN = 32;

`ifdef L2_ARB_DCACHE_PRIORITY_EN
  localparam bit PrioD = 1'b1;
`else
  localparam bit PrioD = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic              icache_l2_req_valid;
  memory_operation_e icache_l2_req_type;
  logic [XLEN-1:0]   icache_l2_req_address;
  logic              icache_l2_req_fulfilled;
  logic              dcache_l2_req_valid;
  memory_operation_e dcache_l2_req_type;
  logic [XLEN-1:0]   dcache_l2_req_address;
  logic [XLEN-1:0]   dcache_l2_req_wdata;
  logic              dcache_l2_req_fulfilled;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic [XLEN-1:0]   l2_req_address;
  logic [XLEN-1:0]   l2_req_wdata;
  logic              l2_req_fulfilled;
  logic              icache_granted;
  logic              dcache_granted;

  int unsigned n_pass;
  int unsigned n_total;

  l2_request_arbiter #(.XLEN(XLEN)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .icache_l2_req_valid    (icache_l2_req_valid),
    .icache_l2_req_type     (icache_l2_req_type),
    .icache_l2_req_address  (icache_l2_req_address),
    .icache_l2_req_fulfilled(icache_l2_req_fulfilled),
    .dcache_l2_req_valid    (dcache_l2_req_valid),
    .dcache_l2_req_type     (dcache_l2_req_type),
    .dcache_l2_req_address  (dcache_l2_req_address),
    .dcache_l2_req_wdata    (dcache_l2_req_wdata),
    .dcache_l2_req_fulfilled(dcache_l2_req_fulfilled),
    .l2_req_valid           (l2_req_valid),
    .l2_req_type            (l2_req_type),
    .l2_req_address         (l2_req_address),
    .l2_req_wdata           (l2_req_wdata),
    .l2_req_fulfilled       (l2_req_fulfilled),
    .icache_granted         (icache_granted),
    .dcache_granted         (dcache_granted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n               = 1'b0;
    icache_l2_req_valid   = 1'b0;
    icache_l2_req_type    = LOAD;
    icache_l2_req_address = '0;
    dcache_l2_req_valid   = 1'b0;
    dcache_l2_req_type    = LOAD;
    dcache_l2_req_address = '0;
    dcache_l2_req_wdata   = '0;
    l2_req_fulfilled      = 1'b0;
    #2;
    n_total++;
    if ({l2_req_valid, icache_granted, dcache_granted} !== 3'b000) begin
      $display("FAIL reset_ctl: got valid/gi/gd=%b required 000",
               {l2_req_valid, icache_granted, dcache_granted});
    end else n_pass++;
    n_total++;
    if (l2_req_type !== LOAD || l2_req_address !== '0 || l2_req_wdata !== '0) begin
      $display("FAIL reset_data: got type=%0d addr=%h wdata=%h required 0/0/0",
               l2_req_type, l2_req_address, l2_req_wdata);
    end else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_icache_alloc();
    icache_l2_req_valid   = 1'b1;
    icache_l2_req_type    = LOAD;
    icache_l2_req_address = 32'h0000_1000;
    #1;
    n_total++;
    if (l2_req_valid !== 1'b0 || icache_granted !== 1'b0) begin
      $display("FAIL ialloc_cycle0: got valid=%b gi=%b required 0 0", l2_req_valid, icache_granted);
    end else n_pass++;
    tick();
    n_total++;
    if (l2_req_valid !== 1'b1 || icache_granted !== 1'b1 || dcache_granted !== 1'b0) begin
      $display("FAIL ialloc_grant: got valid=%b gi=%b gd=%b required 1 1 0",
               l2_req_valid, icache_granted, dcache_granted);
    end else n_pass++;
    for (int b = 0; b < 4; b++) begin
      icache_l2_req_address = 32'h0000_1000 + 32'(b * 4);
      l2_req_fulfilled = 1'b1;
      #1;
      n_total++;
      if (icache_l2_req_fulfilled !== 1'b1 || dcache_l2_req_fulfilled !== 1'b0 ||
          l2_req_address !== 32'h0000_1000 + 32'(b * 4)) begin
        $display("FAIL ialloc_beat%0d: got fi=%b fd=%b addr=%h required 1 0 %h", b,
                 icache_l2_req_fulfilled, dcache_l2_req_fulfilled, l2_req_address,
                 32'h0000_1000 + 32'(b * 4));
      end else n_pass++;
      tick();
    end
    l2_req_fulfilled    = 1'b0;
    icache_l2_req_valid = 1'b0;
    #1;
    n_total++;
    if (l2_req_valid !== 1'b0 || icache_granted !== 1'b1) begin
      $display("FAIL ialloc_release: got valid=%b gi=%b required 0 1", l2_req_valid, icache_granted);
    end else n_pass++;
    tick();
    n_total++;
    if (icache_granted !== 1'b0 || dcache_granted !== 1'b0) begin
      $display("FAIL ialloc_idle: got gi=%b gd=%b required 0 0", icache_granted, dcache_granted);
    end else n_pass++;
  endtask

  task automatic test_tie_after_reset();
    pulse_reset();
    icache_l2_req_valid   = 1'b1;
    icache_l2_req_address = 32'h0000_0040;
    dcache_l2_req_valid   = 1'b1;
    dcache_l2_req_type    = STORE;
    dcache_l2_req_address = 32'h0000_0080;
    dcache_l2_req_wdata   = 32'h1234_5678;
    tick();
    n_total++;
    if ({icache_granted, dcache_granted} !== (PrioD ? 2'b01 : 2'b10)) begin
      $display("FAIL tie_first: got gi/gd=%b required %b", {icache_granted, dcache_granted},
               PrioD ? 2'b01 : 2'b10);
    end else n_pass++;
    if (!PrioD) begin
      l2_req_fulfilled = 1'b1;
      #1;
      n_total++;
      if (dcache_l2_req_fulfilled !== 1'b0 || icache_l2_req_fulfilled !== 1'b1 ||
          l2_req_wdata !== '0 || l2_req_address !== 32'h0000_0040) begin
        $display("FAIL tie_pending: got fd=%b fi=%b wdata=%h addr=%h required 0 1 0 00000040",
                 dcache_l2_req_fulfilled, icache_l2_req_fulfilled, l2_req_wdata, l2_req_address);
      end else n_pass++;
      l2_req_fulfilled    = 1'b0;
      icache_l2_req_valid = 1'b0;
      #1;
      n_total++;
      if (l2_req_valid !== 1'b0) begin
        $display("FAIL tie_release: got valid=%b required 0", l2_req_valid);
      end else n_pass++;
      tick();
      n_total++;
      if (dcache_granted !== 1'b1 || l2_req_valid !== 1'b1 || l2_req_wdata !== 32'h1234_5678) begin
        $display("FAIL tie_switch: got gd=%b valid=%b wdata=%h required 1 1 12345678",
                 dcache_granted, l2_req_valid, l2_req_wdata);
      end else n_pass++;
    end
    icache_l2_req_valid = 1'b0;
    dcache_l2_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    // Previous owner was dcache, so round-robin starts with icache.
    for (int r = 0; r < 3; r++) begin
      icache_l2_req_valid = 1'b1;
      dcache_l2_req_valid = 1'b1;
      tick();
      n_total++;
      if (PrioD) begin
        if (dcache_granted !== 1'b1 || icache_granted !== 1'b0) begin
          $display("FAIL b2b_round%0d: got gi=%b gd=%b required 0 1", r,
                   icache_granted, dcache_granted);
        end else n_pass++;
      end else begin
        if (icache_granted !== (r != 1) || dcache_granted !== (r == 1)) begin
          $display("FAIL b2b_round%0d: got gi=%b gd=%b required %b %b", r,
                   icache_granted, dcache_granted, r != 1, r == 1);
        end else n_pass++;
      end
      icache_l2_req_valid = 1'b0;
      dcache_l2_req_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_writeback();
    dcache_l2_req_valid   = 1'b1;
    dcache_l2_req_type    = STORE;
    dcache_l2_req_address = 32'h0000_2000;
    dcache_l2_req_wdata   = 32'hDEAD_BEEF;
    tick();
    icache_l2_req_valid   = 1'b1;
    icache_l2_req_address = 32'h0000_3000;
    l2_req_fulfilled      = 1'b1;
    #1;
    n_total++;
    if (l2_req_type !== STORE || l2_req_wdata !== 32'hDEAD_BEEF ||
        l2_req_address !== 32'h0000_2000 || dcache_granted !== 1'b1) begin
      $display("FAIL wb_data: got type=%0d wdata=%h addr=%h gd=%b required 1 deadbeef 00002000 1",
               l2_req_type, l2_req_wdata, l2_req_address, dcache_granted);
    end else n_pass++;
    n_total++;
    if (dcache_l2_req_fulfilled !== 1'b1 || icache_l2_req_fulfilled !== 1'b0) begin
      $display("FAIL wb_fulfilled: got fd=%b fi=%b required 1 0",
               dcache_l2_req_fulfilled, icache_l2_req_fulfilled);
    end else n_pass++;
    icache_l2_req_valid = 1'b0;
    dcache_l2_req_valid = 1'b0;
    l2_req_fulfilled    = 1'b0;
    tick();
    l2_req_fulfilled = 1'b1;
    #1;
    n_total++;
    if ({icache_l2_req_fulfilled, dcache_l2_req_fulfilled, l2_req_valid} !== 3'b000) begin
      $display("FAIL idle_spurious: got fi/fd/valid=%b required 000",
               {icache_l2_req_fulfilled, dcache_l2_req_fulfilled, l2_req_valid});
    end else n_pass++;
    l2_req_fulfilled = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    icache_l2_req_valid   = 1'b1;
    icache_l2_req_type    = LOAD;
    icache_l2_req_address = 32'h0000_4000;
    tick();
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({l2_req_valid, icache_granted, dcache_granted} !== 3'b000) begin
      $display("FAIL reset_mid: got valid/gi/gd=%b required 000",
               {l2_req_valid, icache_granted, dcache_granted});
    end else n_pass++;
    tick();
    reset_n             = 1'b1;
    dcache_l2_req_valid = 1'b1;
    dcache_l2_req_type  = LOAD;
    tick();
    n_total++;
    if ({icache_granted, dcache_granted} !== (PrioD ? 2'b01 : 2'b10)) begin
      $display("FAIL reset_tie: got gi/gd=%b required %b", {icache_granted, dcache_granted},
               PrioD ? 2'b01 : 2'b10);
    end else n_pass++;
    icache_l2_req_valid = 1'b0;
    dcache_l2_req_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_icache_alloc();
    test_tie_after_reset();
    test_back_to_back();
    test_writeback();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
